// File: rtl/alu_ve_seq.sv
// Two-port round-robin sequencer for the 24-lane vector-scalar ALU: three 8-lane beats per op.
// Optional macro ALU_VE_DIV_EN enables the lane divider (funct 110); otherwise 110 is unsupported.
module alu_ve_seq #(
    parameter int LANES_PER_BEAT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [191:0] req0_op1,
    input  logic [20:0]  req0_op2,
    input  logic [2:0]   req0_funct,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [191:0] req1_op1,
    input  logic [20:0]  req1_op2,
    input  logic [2:0]   req1_funct,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [191:0] res_data,
    output logic         res_id,
    output logic         res_err,
    output logic         busy
);
    localparam int BW = LANES_PER_BEAT * 8;
    localparam logic [2:0] F_MUL = 3'b100;
    localparam logic [2:0] F_DIV = 3'b110;

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, DONE} state_t;

    state_t         state, state_nxt;
    logic           ptr;
    logic           win;
    logic           accept;
    logic [191:0]   op1_q;
    logic [20:0]    op2_q;
    logic [2:0]     funct_q;
    logic           id_q;
    logic [BW-1:0]  beat_in;
    logic [BW-1:0]  beat_res;
    logic [LANES_PER_BEAT-1:0] lane_err;
    logic           beat_err;

    // Returns {error, lane result}.
    function automatic logic [8:0] lane_calc(input logic [7:0] a, input logic [20:0] b,
                                             input logic [2:0] f);
        logic [8:0] r;
        r = {1'b1, 8'h00};
        if (f == F_MUL) begin
            r = {1'b0, 8'(a * b)};
        end
`ifdef ALU_VE_DIV_EN
        else if (f == F_DIV) begin
            r = (b == '0) ? {1'b1, 8'hFF} : {1'b0, 8'({13'd0, a} / b)};
        end
`endif
        return r;
    endfunction

    // Sole requester wins outright; a tie goes to the pointer.
    always_comb begin
        win = ptr;
        if (req0_valid && !req1_valid) win = 1'b0;
        else if (req1_valid && !req0_valid) win = 1'b1;
    end

    assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !win;
    assign req1_ready = accept && win;

    always_comb begin
        beat_in = '0;
        case (state)
            BEAT0:   beat_in = op1_q[BW-1:0];
            BEAT1:   beat_in = op1_q[2*BW-1:BW];
            BEAT2:   beat_in = op1_q[3*BW-1:2*BW];
            default: beat_in = '0;
        endcase
    end

    for (genvar g = 0; g < LANES_PER_BEAT; g++) begin : g_lane
        logic [8:0] lane_out;
        assign lane_out            = lane_calc(beat_in[8*g +: 8], op2_q, funct_q);
        assign beat_res[8*g +: 8]  = lane_out[7:0];
        assign lane_err[g]         = lane_out[8];
    end
    assign beat_err = |lane_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BEAT0;
            BEAT0:   state_nxt = BEAT1;
            BEAT1:   state_nxt = BEAT2;
            BEAT2:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            funct_q  <= '0;
            id_q     <= 1'b0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            if (accept) begin
                op1_q   <= win ? req1_op1 : req0_op1;
                op2_q   <= win ? req1_op2 : req0_op2;
                funct_q <= win ? req1_funct : req0_funct;
                id_q    <= win;
                ptr     <= ~win;
                res_err <= 1'b0;
            end
            case (state)
                BEAT0:   res_data[BW-1:0]      <= beat_res;
                BEAT1:   res_data[2*BW-1:BW]   <= beat_res;
                BEAT2:   res_data[3*BW-1:2*BW] <= beat_res;
                default: ;
            endcase
            if (state == BEAT0 || state == BEAT1 || state == BEAT2)
                res_err <= res_err | beat_err;
        end
    end

    assign res_valid = (state == DONE);
    assign res_id    = id_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_ve_seq.sv
// Directed bench for alu_ve_seq: vector table plus arbitration, backpressure and reset sequences.
module tb_alu_ve_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [191:0] req0_op1, req1_op1;
    logic [20:0]  req0_op2, req1_op2;
    logic [2:0]   req0_funct, req1_funct;
    logic         res_valid, res_ready, res_id, res_err, busy;
    logic [191:0] res_data;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ve_seq dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_funct(req1_funct),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [191:0] op1;
        logic [20:0]  op2;
        logic [2:0]   funct;
        logic [191:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [191:0] fill(input logic [7:0] b);
        return {24{b}};
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic id, input logic [191:0] a, input logic [20:0] b,
                          input logic [2:0] f, output logic [191:0] d, output logic e,
                          output logic rid, output int lat);
        int n;
        d = '0; e = 1'b0; rid = 1'b0; lat = 0; n = 0;
        res_ready = 1'b0;
        if (!id) begin
            req0_op1 = a; req0_op2 = b; req0_funct = f; req0_valid = 1'b1;
        end else begin
            req1_op1 = a; req1_op2 = b; req1_funct = f; req1_valid = 1'b1;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            step(); #1; n++;
        end
        if (n >= 20) begin
            chk("grant_timeout", 192'(n), 192'd0);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        step();
        // Scramble request inputs after acceptance; the result must not depend on them.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op1 = ~a; req1_op1 = ~a; req0_op2 = ~b; req1_op2 = ~b;
        req0_funct = 3'b110; req1_funct = 3'b110;
        lat = 1;
        #1;
        while (!res_valid && lat < 20) begin
            step(); #1; lat++;
        end
        d = res_data; e = res_err; rid = res_id;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        logic [191:0] d, sd;
        logic         e, rid, sid;
        int           lat, ng, nr, hi;
        logic         gid[4], rida[4];
        int           gcyc[4], rcyc[4];
        logic [191:0] rdat[4];

        for (int k = 0; k < 4; k++) begin
            gid[k] = 1'bx; rida[k] = 1'bx; gcyc[k] = -100; rcyc[k] = -100; rdat[k] = 'x;
        end

        vecs[0] = '{fill(8'h03), 21'd5, 3'b100, fill(8'h0F), 1'b0};
        vecs[1] = '{{176'd0, 8'd7, 8'd200}, 21'd3, 3'b100, {176'd0, 8'h15, 8'h58}, 1'b0};
`ifdef ALU_VE_DIV_EN
        vecs[2] = '{{176'd0, 8'd7, 8'd200}, 21'd3, 3'b110, {176'd0, 8'd2, 8'd66}, 1'b0};
        vecs[3] = '{fill(8'h5A), 21'd0, 3'b110, fill(8'hFF), 1'b1};
        vecs[6] = '{fill(8'hFF), 21'd256, 3'b110, 192'd0, 1'b0};
        vecs[8] = '{192'd0, 21'd7, 3'b110, 192'd0, 1'b0};
`else
        vecs[2] = '{{176'd0, 8'd7, 8'd200}, 21'd3, 3'b110, 192'd0, 1'b1};
        vecs[3] = '{fill(8'h5A), 21'd0, 3'b110, 192'd0, 1'b1};
        vecs[6] = '{fill(8'hFF), 21'd256, 3'b110, 192'd0, 1'b1};
        vecs[8] = '{192'd0, 21'd7, 3'b110, 192'd0, 1'b1};
`endif
        vecs[4] = '{fill(8'h77), 21'd9, 3'b011, 192'd0, 1'b1};
        vecs[5] = '{fill(8'h10), 21'h100011, 3'b100, fill(8'h10), 1'b0};
        vecs[7] = '{192'd0, 21'd13, 3'b100, 192'd0, 1'b0};
        for (int i = 0; i < 24; i++) begin
            vecs[7].op1[8*i +: 8]      = 8'(i + 1);
            vecs[7].exp_data[8*i +: 8] = 8'((i + 1) * 13);
            vecs[8].op1[8*i +: 8]      = 8'(i * 10);
`ifdef ALU_VE_DIV_EN
            vecs[8].exp_data[8*i +: 8] = 8'((i * 10) / 7);
`endif
        end

        req0_op1 = '0; req0_op2 = '0; req0_funct = '0;
        req1_op1 = '0; req1_op2 = '0; req1_funct = '0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        rst = 1'b1;
        #3;
        chk("reset_ctrl", 192'({res_valid, busy, req0_ready, req1_ready, res_id, res_err}), 192'd0);
        chk("reset_data", res_data, 192'd0);
        do_reset();

        // Table vectors, alternating requesters.
        for (int i = 0; i < 9; i++) begin
            run_op(1'(i), vecs[i].op1, vecs[i].op2, vecs[i].funct, d, e, rid, lat);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), 192'(e), 192'(vecs[i].exp_err));
            chk($sformatf("vec%0d_id", i), 192'(rid), 192'(i % 2));
            chk($sformatf("vec%0d_latency", i), 192'(lat), 192'd4);
        end

        // Arbitration: both requesters valid continuously after reset.
        do_reset();
        req0_op1 = fill(8'h02); req0_op2 = 21'd3; req0_funct = 3'b100;
        req1_op1 = fill(8'h04); req1_op2 = 21'd3; req1_funct = 3'b100;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        ng = 0; nr = 0;
        for (int c = 0; c < 60 && nr < 3; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                if (ng < 4) begin gid[ng] = req1_ready; gcyc[ng] = c; end
                ng++;
            end
            if (res_valid) begin
                if (nr < 4) begin rida[nr] = res_id; rcyc[nr] = c; rdat[nr] = res_data; end
                nr++;
                if (nr == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
            step();
        end
        res_ready = 1'b0;
        chk("arb_grants", 192'(ng), 192'd3);
        chk("arb_results", 192'(nr), 192'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arb_grant%0d_id", k), 192'(gid[k]), 192'(k % 2));
            chk($sformatf("arb_res%0d_id", k), 192'(rida[k]), 192'(k % 2));
            chk($sformatf("arb_res%0d_data", k), rdat[k], (k % 2) ? fill(8'h0C) : fill(8'h06));
            chk($sformatf("arb_res%0d_latency", k), 192'(rcyc[k] - gcyc[k]), 192'd4);
            if (k > 0)
                chk($sformatf("arb_grant%0d_gap", k), 192'(gcyc[k] - rcyc[k-1]), 192'd1);
        end

        // Backpressure: pointer now favours req1 on a tie.
        req0_op1 = fill(8'h09); req0_op2 = 21'd1; req0_funct = 3'b100;
        req1_op1 = fill(8'h05); req1_op2 = 21'd2; req1_funct = 3'b100;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        lat = 0;
        #1;
        while (!res_valid && lat < 20) begin step(); #1; lat++; end
        chk("bp_reached_done", 192'(res_valid), 192'd1);
        sd = res_data; sid = res_id;
        chk("bp_data", sd, fill(8'h0A));
        chk("bp_id", 192'(sid), 192'd1);
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            chk($sformatf("bp_hold%0d_ctrl", k),
                192'({res_valid, res_id, req0_ready, req1_ready, busy}), 192'({1'b1, sid, 3'b001}));
            chk($sformatf("bp_hold%0d_data", k), res_data, sd);
        end
        step();
        res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        res_ready = 1'b0;
        #1;
        chk("bp_release_idle", 192'({res_valid, busy}), 192'd0);

        // Reset during BEAT1 after a req0 grant (pointer would favour req1).
        step();
        req0_op1 = fill(8'h01); req0_op2 = 21'd1; req0_funct = 3'b100; req0_valid = 1'b1;
        #1;
        chk("rst_pre_grant", 192'(req0_ready), 192'd1);
        step();
        req0_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1; rst = 1'b1;
        #1;
        chk("rst_beat1_ctrl", 192'({res_valid, busy, req0_ready, req1_ready, res_id, res_err}), 192'd0);
        chk("rst_beat1_data", res_data, 192'd0);
        step(); step();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (res_valid || busy) hi++;
            step();
        end
        chk("rst_no_result", 192'(hi), 192'd0);
        req0_op1 = fill(8'h21); req0_op2 = 21'd2; req0_funct = 3'b100;
        req1_op1 = fill(8'h11); req1_op2 = 21'd1; req1_funct = 3'b100;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ptr_grant", 192'({req0_ready, req1_ready}), 192'(2'b10));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 1;
        #1;
        while (!res_valid && lat < 20) begin step(); #1; lat++; end
        chk("rst_after_data", res_data, fill(8'h42));
        chk("rst_after_id", 192'(res_id), 192'd0);
        chk("rst_after_latency", 192'(lat), 192'd4);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_ve_seq.md
# alu_ve_seq

Sequencer and two-port arbiter for the vector-scalar ALU datapath (24 lanes × 8 bits, 21-bit scalar, funct 100 = multiply, 110 = divide). It accepts vector-scalar operations from two requesters over valid/ready and grants them round-robin. Each granted operation is processed as three 8-lane beats through a shared lane-group arithmetic unit, and the result is returned over a valid/ready port. It sits between the vector register-read stage and vector writeback.

## Interface
- LANES_PER_BEAT, 8, lanes processed per beat; fixed, 24 must be divisible by it.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op1  in  192  24 unsigned 8-bit lanes; lane i = bits [8i+7:8i].
- req0_op2  in  21  unsigned scalar.
- req0_funct  in  3  operation code.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_funct  same as requester 0.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  192  lane results.
- res_id  out  1  requester that issued the operation.
- res_err  out  1  divide-by-zero or unsupported funct.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, BEAT0, BEAT1, BEAT2, DONE.
- IDLE:
  - Arbitrate among the asserted reqN_valid.
  - With a single requester, that requester wins.
  - With both, the requester selected by the priority pointer wins. The pointer is 0 after reset and after each grant points to the other requester.
  - reqN_ready is combinational: 1 only in IDLE, only for the winner, only when its valid is 1.
  - On handshake, latch op1, op2, funct and id; go to BEAT0.
- BEATk (k = 0..2):
  - Compute lanes 8k..8k+7 from the latched operands.
  - Write the results into the result register.
  - OR the beat's error into the sticky error bit.
  - Advance to the next state; BEAT2 goes to DONE.
- DONE: res_valid = 1. When res_ready = 1, go to IDLE.
- Lane arithmetic, operands unsigned:
  - funct 100: result = low 8 bits of lane × op2.
  - funct 110 with op2 ≠ 0: result = lane / op2, truncating; a quotient is 0 when op2 > lane.
  - funct 110 with op2 = 0: lane result 8'hFF and the error bit is set.
  - Any other funct: lane result 8'h00 and the error bit is set.
- Latched operands are held for the whole operation; changes on req inputs after acceptance are ignored.
- res_data, res_id and res_err are stable from the DONE entry until the handshake.

## Timing
- Handshake in cycle T; BEAT0/1/2 in T+1, T+2, T+3; res_valid = 1 from T+4.
- Minimum latency is 4 cycles.
- Throughput is at most one operation per 5 cycles: a result handshake in cycle U allows the next acceptance in cycle U+1, never in U.
- res_valid with res_ready low: the block holds DONE indefinitely. Both reqN_ready stay 0 during the stall.
- Reset values: state IDLE, res_valid 0, res_data 0, res_id 0, res_err 0, busy 0, pointer 0, both reqN_ready 0.
- Reset mid-operation discards the operation. No result is produced and no ready is asserted. The first cycle after reset release is IDLE.
- A requester that drops valid without being granted loses nothing; no request is queued internally.

## Configuration
- ALU_VE_DIV_EN defined: the divider is instantiated and funct 110 behaves as specified above.
- ALU_VE_DIV_EN undefined: no divider logic. funct 110 is treated as unsupported: all lanes 8'h00, res_err = 1, same 4-cycle latency.

## Test plan
- Single multiply: req0 op1 lanes all 8'h03, op2 = 5, funct 100 → res_valid at T+4, all lanes 8'h0F, res_id 0, res_err 0.
- Truncation and divide: lane0 = 200, lane1 = 7, others 0, op2 = 3, funct 100 → lane0 8'h58, lane1 8'h15. The same operands with funct 110 (DIV_EN) give lane0 66, lane1 2.
- Divide by zero: funct 110, op2 = 0 → all lanes 8'hFF, res_err 1. With DIV_EN undefined → all lanes 8'h00, res_err 1.
- Arbitration: both valid continuously after reset.
  - Grants alternate req0, req1, req0; res_id sequence is 0, 1, 0.
  - Each grant is accepted exactly 1 cycle after the previous result handshake.
- Backpressure: hold res_ready 0 for 10 cycles → res_valid, res_data and res_id are stable, both readys are 0, busy is 1. Release → handshake, then IDLE.
- Reset in BEAT1 → all outputs return to reset values, no result is emitted, and the pointer returns to 0 so the next simultaneous request is granted to req0.
